pb_debounce_fsm: RTL

//  Debounces the raw active-low GO push-button and produces the one-cycle 'released' strobe

---
 rtl/pb_pkg.sv | 23 ++
 rtl/pb_synch.sv | 29 ++
 rtl/pb_debounce_fsm.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pb_pkg.sv
// Shared types and length selection for the GO push-button debouncer.
// Contents:
//   pb_state_t  - debouncer FSM state encoding
//   sel_len()   - picks the hardware or fast-simulation length
//   max2()      - larger of two lengths, used to size the shared counter width
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_WT = 2'd1,
        HELD     = 2'd2,
        REL_WT   = 2'd3
    } pb_state_t;

    function automatic int sel_len(input int fast, input int full_len, input int sim_len);
        return (fast != 0) ? sim_len : full_len;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_synch.sv
// Three-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so that an idle, active-low button reads as "up".
// Ports:
//   clk  in  1  system clock
//   rst  in  1  asynchronous, active-high reset
//   d    in  1  asynchronous input
//   q    out 1  third-stage synchronized value
module pb_synch #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign q = sync_q[2];

endmodule

// File: rtl/pb_debounce_fsm.sv
// Counter-qualified debouncer for the active-low GO push-button.
// Produces a one-cycle 'released' strobe (starts the fanfare player), a 'held' level
// while a debounced press is in effect, and a one-cycle 'long_press' strobe once per press.
// Ports:
//   clk         in  1  system clock
//   rst         in  1  asynchronous, active-high reset
//   PB          in  1  raw push-button, active-low, asynchronous to clk
//   released    out 1  one-cycle pulse when a debounced release completes
//   held        out 1  high while a debounced press is in effect
//   long_press  out 1  one-cycle pulse when hold time reaches the long-press length
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | button up, waiting for a low level
// PRESS_WT | low seen, qualifying the press over the debounce window
// HELD     | press accepted, long-press counter running
// REL_WT   | high seen while held, qualifying the release
module pb_debounce_fsm
    import pb_pkg::*;
#(
    parameter int FAST_SIM    = 0,
    parameter int DB_CYCLES   = 500000,
    parameter int LONG_CYCLES = 50000000,
    parameter int DB_SIM      = 16,
    parameter int LONG_SIM    = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic PB,
    output logic released,
    output logic held,
    output logic long_press
);

    localparam int DB_LEN   = sel_len(FAST_SIM, DB_CYCLES, DB_SIM);
    localparam int LONG_LEN = sel_len(FAST_SIM, LONG_CYCLES, LONG_SIM);
    localparam int CW       = $clog2(max2(DB_LEN, LONG_LEN) + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_LEN - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_LEN - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_LEN);

    logic      pb_s;
    pb_state_t state_q;
    logic [CW-1:0] db_cnt_q;
    logic [CW-1:0] long_cnt_q;
    logic [CW-1:0] db_cnt_d;
    logic [CW-1:0] long_cnt_d;
    logic      released_q;
    logic      held_q;
    logic      long_q;

    pb_synch #(.RST_VAL(1'b1)) u_synch (
        .clk (clk),
        .rst (rst),
        .d   (PB),
        .q   (pb_s)
    );

    // Saturating increments. The long-press count parks at LONG_LEN so that the
    // LONG_LEN-1 compare can only match once per press.
    assign db_cnt_d   = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + 1'b1;
    assign long_cnt_d = (long_cnt_q == LONG_MAX) ? long_cnt_q : long_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            released_q <= 1'b0;
            held_q     <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            released_q <= 1'b0;
            long_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    held_q <= 1'b0;
                    if (!pb_s) begin
                        state_q    <= PRESS_WT;
                        db_cnt_q   <= '0;
                        long_cnt_q <= '0;
                    end
                end
                PRESS_WT: begin
                    if (pb_s) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q  <= HELD;
                        db_cnt_q <= '0;
                        held_q   <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_d;
                    end
                end
                HELD: begin
                    held_q     <= 1'b1;
                    long_cnt_q <= long_cnt_d;
                    if (long_cnt_q == LONG_LAST) begin
                        long_q <= 1'b1;
                    end
                    if (pb_s) begin
                        state_q  <= REL_WT;
                        db_cnt_q <= '0;
                    end
                end
                REL_WT: begin
                    // Long-press count is left untouched here, so a bounce back to
                    // HELD resumes the hold time instead of restarting it.
                    if (!pb_s) begin
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= IDLE;
                        db_cnt_q   <= '0;
                        held_q     <= 1'b0;
                        released_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign released   = released_q;
    assign held       = held_q;
    assign long_press = long_q;

endmodule
